padded_pixel_feeder: RTL and testbench

PADDED_PIXEL_FEEDER -- requirements
Module: padded_pixel_feeder

---
 rtl/feeder_pkg.sv | 12 +
 rtl/raster_counter.sv | 39 +++
 rtl/padded_pixel_feeder.sv | 119 +++++++++++
 tb/tb_padded_pixel_feeder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared types and constants for the padded pixel feeder.
package feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feeder_state_e;

  localparam int unsigned PAD_VALUE = 0;

endpackage

// File: rtl/raster_counter.sv
// Row/column raster scanner over a PW x PH frame, column fastest, wrapping to the origin.
module raster_counter #(
  parameter int PW = 30,
  parameter int PH = 30,
  localparam int CW = (PW > 1) ? $clog2(PW) : 1,
  localparam int RW = (PH > 1) ? $clog2(PH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  logic col_end;

  assign col_end = (col == CW'(PW - 1));
  assign last    = col_end && (row == RW'(PH - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/padded_pixel_feeder.sv
// Streams a zero-padded image into a downstream shift register, one position per strobe.
// Optional abort input is enabled by defining PADDED_FEEDER_ABORT_EN.
module padded_pixel_feeder
  import feeder_pkg::*;
#(
  parameter int N         = 8,
  parameter int ImgWidth  = 28,
  parameter int ImgHeight = 28,
  parameter int Pad       = 1,
  parameter int Kernel    = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [N-1:0] pixel_i,
  input  logic         pixel_valid_i,
`ifdef PADDED_FEEDER_ABORT_EN
  input  logic         abort_i,
`endif
  output logic         pixel_ready_o,
  output logic         shift_en_o,
  output logic [N-1:0] shift_data_o,
  output logic         window_valid_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int PW = ImgWidth + 2 * Pad;
  localparam int PH = ImgHeight + 2 * Pad;
  localparam int CW = (PW > 1) ? $clog2(PW) : 1;
  localparam int RW = (PH > 1) ? $clog2(PH) : 1;

  feeder_state_e state_q, state_d;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          last;
  logic          is_pad;
  logic          advance;
  logic          abort_req;
  logic          frame_end_q;
  logic          win_pos;

`ifdef PADDED_FEEDER_ABORT_EN
  assign abort_req = (state_q == RUN) && abort_i;
`else
  assign abort_req = 1'b0;
`endif

  assign is_pad = (int'(row) < Pad) || (int'(row) >= Pad + ImgHeight) ||
                  (int'(col) < Pad) || (int'(col) >= Pad + ImgWidth);
  assign win_pos = (int'(row) >= Kernel - 1) && (int'(col) >= Kernel - 1);

  raster_counter #(
    .PW(PW),
    .PH(PH)
  ) u_raster (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  ((state_q != RUN) || abort_req),
    .advance(advance),
    .row    (row),
    .col    (col),
    .last   (last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // frame_end_q holds RUN for the cycle the last strobe is presented, so DONE follows it
  always_comb begin
    state_d       = state_q;
    advance       = 1'b0;
    pixel_ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (abort_req) begin
          state_d = IDLE;
        end else if (frame_end_q) begin
          state_d = DONE;
        end else begin
          pixel_ready_o = !is_pad;
          advance       = is_pad || pixel_valid_i;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_end_q    <= 1'b0;
      shift_en_o     <= 1'b0;
      shift_data_o   <= '0;
      window_valid_o <= 1'b0;
    end else begin
      frame_end_q    <= advance && last;
      shift_en_o     <= advance;
      shift_data_o   <= !advance ? '0 : (is_pad ? N'(PAD_VALUE) : pixel_i);
      window_valid_o <= advance && win_pos;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_padded_pixel_feeder.sv
// Directed bench for padded_pixel_feeder: padded 4x4 frame, unpadded 3x3 frame, reset and start corner cases.
module tb_padded_pixel_feeder;

  logic       clk;
  logic       rst_n;
  logic       start_a;
  logic       start_b;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       sel_b;
`ifdef PADDED_FEEDER_ABORT_EN
  logic       abort_a;
`endif

  logic       ready_a, en_a, win_a, busy_a, done_a;
  logic [7:0] data_a;
  logic       ready_b, en_b, win_b, busy_b, done_b;
  logic [7:0] data_b;

  int compared   = 0;
  int mismatched = 0;

  padded_pixel_feeder #(
    .N(8), .ImgWidth(4), .ImgHeight(4), .Pad(1), .Kernel(3)
  ) dut_a (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start_a),
    .pixel_i       (pix_data),
    .pixel_valid_i (pix_valid),
`ifdef PADDED_FEEDER_ABORT_EN
    .abort_i       (abort_a),
`endif
    .pixel_ready_o (ready_a),
    .shift_en_o    (en_a),
    .shift_data_o  (data_a),
    .window_valid_o(win_a),
    .busy_o        (busy_a),
    .done_o        (done_a)
  );

  padded_pixel_feeder #(
    .N(8), .ImgWidth(3), .ImgHeight(3), .Pad(0), .Kernel(3)
  ) dut_b (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start_b),
    .pixel_i       (pix_data),
    .pixel_valid_i (pix_valid),
`ifdef PADDED_FEEDER_ABORT_EN
    .abort_i       (1'b0),
`endif
    .pixel_ready_o (ready_b),
    .shift_en_o    (en_b),
    .shift_data_o  (data_b),
    .window_valid_o(win_b),
    .busy_o        (busy_b),
    .done_o        (done_b)
  );

  wire       obs_ready = sel_b ? ready_b : ready_a;
  wire       obs_en    = sel_b ? en_b    : en_a;
  wire       obs_win   = sel_b ? win_b   : win_a;
  wire       obs_busy  = sel_b ? busy_b  : busy_a;
  wire       obs_done  = sel_b ? done_b  : done_a;
  wire [7:0] obs_data  = sel_b ? data_b  : data_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Watches the selected DUT for a few cycles and returns strobes and busy/done cycles seen.
  task automatic idleWatch(input int cycles, output int activity);
    activity = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (obs_en || obs_busy || obs_done) activity++;
    end
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input bit use_b, input int w, input int h, input int p, input int k,
                               input int period, input bit hold_start, input int reset_at,
                               input int abort_at);
    int pw, ph, idx, cyc, strobes, hs, wins, dones, stall_strobes, last_cyc, done_cyc;
    int r, c, exp_data, activity;
    bit interior, prev_stall, stop;
    pw = w + 2 * p;
    ph = h + 2 * p;
    idx = 0; cyc = 0; strobes = 0; hs = 0; wins = 0; dones = 0;
    stall_strobes = 0; last_cyc = -1; done_cyc = -1;
    prev_stall = 1'b0; stop = 1'b0;
    sel_b = use_b;
    pix_valid = 1'b0;
    @(posedge clk); #1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) begin
      start_a = 1'b0;
      start_b = 1'b0;
    end
    while (!stop && cyc < 2000) begin
      pix_valid = ((cyc % period) == 0);
      pix_data  = 8'(idx + 1);
      @(negedge clk);
      if (obs_en) begin
        r = strobes / pw;
        c = strobes % pw;
        interior = (r >= p) && (r < p + h) && (c >= p) && (c < p + w);
        exp_data = interior ? (r - p) * w + (c - p) + 1 : 0;
        checkOutput("shiftData", int'(obs_data), exp_data);
        checkOutput("windowValid", int'(obs_win), int'((r >= k - 1) && (c >= k - 1)));
        if (prev_stall) stall_strobes++;
        if (obs_win) wins++;
        strobes++;
        last_cyc = cyc;
      end
      prev_stall = obs_ready && !pix_valid;
      if (pix_valid && obs_ready) begin
        hs++;
        idx++;
      end
      if (obs_done) begin
        dones++;
        done_cyc = cyc;
        stop = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
      end
      if (reset_at > 0 && strobes == reset_at) begin
        rst_n = 1'b0;
        #1;
        checkOutput("resetOutputs",
                    int'({obs_ready, obs_en, obs_win, obs_busy, obs_done, obs_data}), 0);
        stop = 1'b1;
      end
`ifdef PADDED_FEEDER_ABORT_EN
      if (abort_at > 0 && strobes == abort_at && !stop) begin
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        checkOutput("abortBusy", int'(obs_busy), 0);
        idleWatch(5, activity);
        checkOutput("abortQuiet", activity, 0);
        stop = 1'b1;
      end
`endif
      if (!stop) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    pix_valid = 1'b0;
    checkOutput("frameEnded", int'(stop), 1);
    if (reset_at == 0 && abort_at == 0) begin
      checkOutput("strobeCount", strobes, pw * ph);
      checkOutput("handshakeCount", hs, w * h);
      checkOutput("windowCount", wins, (ph - k + 1) * (pw - k + 1));
      checkOutput("doneCount", dones, 1);
      checkOutput("stallStrobes", stall_strobes, 0);
      checkOutput("doneLatency", done_cyc - last_cyc, 1);
      @(posedge clk); #1;
      idleWatch(4, activity);
      checkOutput("idleAfterDone", activity, 0);
    end
  endtask

  int activity;

  initial begin
    rst_n     = 1'b0;
    start_a   = 1'b0;
    start_b   = 1'b0;
    pix_data  = '0;
    pix_valid = 1'b0;
    sel_b     = 1'b0;
`ifdef PADDED_FEEDER_ABORT_EN
    abort_a   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetStateA", int'({ready_a, en_a, win_a, busy_a, done_a, data_a}), 0);
    checkOutput("resetStateB", int'({ready_b, en_b, win_b, busy_b, done_b, data_b}), 0);
    rst_n = 1'b1;

    $display("[TB] padded 4x4 frame, valid every cycle");
    applyStimulus(1'b0, 4, 4, 1, 3, 1, 1'b0, 0, 0);

    $display("[TB] padded 4x4 frame, valid one cycle in three");
    applyStimulus(1'b0, 4, 4, 1, 3, 3, 1'b0, 0, 0);

    $display("[TB] unpadded 3x3 frame");
    applyStimulus(1'b1, 3, 3, 0, 3, 1, 1'b0, 0, 0);

    $display("[TB] reset after tenth strobe, then full frame");
    applyStimulus(1'b0, 4, 4, 1, 3, 1, 1'b0, 10, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idleWatch(4, activity);
    checkOutput("quietAfterReset", activity, 0);
    applyStimulus(1'b0, 4, 4, 1, 3, 1, 1'b0, 0, 0);

    $display("[TB] start held high through the frame");
    applyStimulus(1'b0, 4, 4, 1, 3, 1, 1'b1, 0, 0);

`ifdef PADDED_FEEDER_ABORT_EN
    $display("[TB] abort at twentieth strobe, then full frame");
    applyStimulus(1'b0, 4, 4, 1, 3, 1, 1'b0, 0, 20);
    applyStimulus(1'b0, 4, 4, 1, 3, 1, 1'b0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
